// File: rtl/color_vote_controller.sv
// Per-frame colour vote: counts ROI-qualified pixels, decides once per frame, debounces the
// decisions and runs the turn FSM that drives the overlay and the game-logic result handshake.
module color_vote_controller #(
  parameter int unsigned ROI_X_START   = 100,
  parameter int unsigned ROI_X_END     = 220,
  parameter int unsigned ROI_Y_START   = 60,
  parameter int unsigned ROI_Y_END     = 180,
  parameter int unsigned CNT_W         = 15,
  parameter int unsigned MIN_PIXELS    = 2000,
  parameter int unsigned WHITE_PIXELS  = 10000,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  input  logic [8:0] pix_x,
  input  logic [7:0] pix_y,
  input  logic       is_red,
  input  logic       is_green,
  input  logic       is_blue,
  input  logic       is_white,
  input  logic       frame_end,
  input  logic       result_ack,
  output logic [1:0] dominant_color,
  output logic       white_detected,
  output logic       result_valid,
  output logic [2:0] frame_color
);

  localparam int unsigned SW = $clog2(STABLE_FRAMES + 1);
  localparam logic [8:0] XLo = 9'(ROI_X_START);
  localparam logic [8:0] XHi = 9'(ROI_X_END);
  localparam logic [7:0] YLo = 8'(ROI_Y_START);
  localparam logic [7:0] YHi = 8'(ROI_Y_END);
  localparam logic [CNT_W-1:0] MinPix   = CNT_W'(MIN_PIXELS);
  localparam logic [CNT_W-1:0] WhitePix = CNT_W'(WHITE_PIXELS);
  localparam logic [SW-1:0]    StableMax = SW'(STABLE_FRAMES);

  localparam logic [2:0] DecNone  = 3'd0;
  localparam logic [2:0] DecRed   = 3'd1;
  localparam logic [2:0] DecGreen = 3'd2;
  localparam logic [2:0] DecBlue  = 3'd3;
  localparam logic [2:0] DecWhite = 3'd4;

  typedef enum logic [1:0] {StWhite, StArmed, StReport, StHold} state_e;

  logic [3:0]            flags;
  logic                  one_hot, in_roi, qual;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_inc;
  logic [2:0]            dec;
  logic [2:0]            frame_color_q;
  logic                  dec_valid_q;
  logic [2:0]            cand_q, cand_d;
  logic [SW-1:0]         stable_q, stable_d;
  logic                  stable_hit;
  state_e                state_q, state_d;
  logic [1:0]            latch_q, latch_d;
  logic [1:0]            dom_q, dom_d;
  logic                  white_q, valid_q;

  // Index order r, g, b, w matches cnt_q.
  assign flags   = {is_white, is_blue, is_green, is_red};
  assign one_hot = (flags != 4'd0) && ((flags & (flags - 4'd1)) == 4'd0);
  assign in_roi  = (pix_x >= XLo) && (pix_x < XHi) && (pix_y >= YLo) && (pix_y < YHi);
  assign qual    = pix_valid && in_roi && one_hot;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_inc[i] = cnt_q[i];
      if (qual && flags[i] && (cnt_q[i] != '1)) cnt_inc[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  // Decision on the snapshot, which includes a pixel qualified in the frame_end cycle.
  always_comb begin
    dec = DecNone;
    if (cnt_inc[3] >= WhitePix) begin
      dec = DecWhite;
    end else if (cnt_inc[0] > cnt_inc[1] && cnt_inc[0] > cnt_inc[2] && cnt_inc[0] >= MinPix) begin
      dec = DecRed;
    end else if (cnt_inc[1] > cnt_inc[0] && cnt_inc[1] > cnt_inc[2] && cnt_inc[1] >= MinPix) begin
      dec = DecGreen;
    end else if (cnt_inc[2] > cnt_inc[0] && cnt_inc[2] > cnt_inc[1] && cnt_inc[2] >= MinPix) begin
      dec = DecBlue;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      frame_color_q <= DecNone;
      dec_valid_q   <= 1'b0;
    end else begin
      cnt_q       <= frame_end ? '0 : cnt_inc;
      dec_valid_q <= frame_end;
      if (frame_end) frame_color_q <= dec;
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    if (dec_valid_q) begin
      if (frame_color_q == cand_q) begin
        if (stable_q != StableMax) stable_d = stable_q + SW'(1);
      end else begin
        cand_d   = frame_color_q;
        stable_d = SW'(1);
      end
    end
    stable_hit = dec_valid_q && (stable_d == StableMax);

    unique case (state_q)
      StWhite: if (dec_valid_q && frame_color_q != DecWhite) state_d = StArmed;
      StArmed: begin
        if (stable_hit && cand_d != DecNone) begin
          if (cand_d == DecWhite) begin
            state_d = StWhite;
          end else begin
            state_d = StReport;
            latch_d = cand_d[1:0];
          end
        end
      end
      StReport: begin
        // Ack wins over a coincident decision; HOLD starts with a fresh debounce.
        if (result_ack) begin
          state_d  = StHold;
          cand_d   = DecNone;
          stable_d = '0;
        end
      end
      StHold: begin
        if (stable_hit && cand_d == DecWhite) begin
          state_d = StWhite;
          latch_d = 2'd0;
        end
      end
      default: state_d = StWhite;
    endcase

    dom_d = (state_d == StReport || state_d == StHold) ? latch_d : 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StWhite;
      latch_q  <= 2'd0;
      cand_q   <= DecNone;
      stable_q <= '0;
      dom_q    <= 2'd0;
      white_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      latch_q  <= latch_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      dom_q    <= dom_d;
      white_q  <= (state_d == StWhite);
      valid_q  <= (state_d == StReport);
    end
  end

  assign dominant_color = dom_q;
  assign white_detected = white_q;
  assign result_valid   = valid_q;
  assign frame_color    = frame_color_q;

endmodule

// File: tb/tb_color_vote_controller.sv
// Scoreboard bench for color_vote_controller: expected frame decisions are queued at frame_end
// and popped when frame_color updates; FSM outputs are checked directly against expectations.
module tb_color_vote_controller;

  localparam int MinPx   = 2000;
  localparam int WhitePx = 500;
  localparam int SatMax  = 32767;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pix_valid = 1'b0;
  logic [8:0] pix_x = '0;
  logic [7:0] pix_y = '0;
  logic       is_red = 1'b0, is_green = 1'b0, is_blue = 1'b0, is_white = 1'b0;
  logic       frame_end = 1'b0;
  logic       result_ack = 1'b0;
  logic [1:0] dominant_color;
  logic       white_detected;
  logic       result_valid;
  logic [2:0] frame_color;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic fe_d;

  color_vote_controller #(
    .WHITE_PIXELS(WhitePx)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pix_valid     (pix_valid),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .is_red        (is_red),
    .is_green      (is_green),
    .is_blue       (is_blue),
    .is_white      (is_white),
    .frame_end     (frame_end),
    .result_ack    (result_ack),
    .dominant_color(dominant_color),
    .white_detected(white_detected),
    .result_valid  (result_valid),
    .frame_color   (frame_color)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int dom, input int white, input int valid);
    check({tag, ".dominant_color"}, dominant_color, dom);
    check({tag, ".white_detected"}, white_detected, white);
    check({tag, ".result_valid"}, result_valid, valid);
  endtask

  function automatic int sat(input int n);
    return (n > SatMax) ? SatMax : n;
  endfunction

  function automatic int decide(input int r0, input int g0, input int b0, input int w0);
    int r, g, b, w;
    r = sat(r0); g = sat(g0); b = sat(b0); w = sat(w0);
    if (w >= WhitePx) return 4;
    if (r > g && r > b && r >= MinPx) return 1;
    if (g > r && g > b && g >= MinPx) return 2;
    if (b > r && b > g && b >= MinPx) return 3;
    return 0;
  endfunction

  // Decision appears on frame_color in the cycle after frame_end.
  always @(posedge clk or negedge reset) begin
    if (!reset) fe_d <= 1'b0;
    else        fe_d <= frame_end;
  end

  always @(negedge clk) begin
    if (fe_d) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check("frame_color", frame_color, exp_q.pop_front());
    end
  end

  task automatic set_flags(input logic [3:0] f);
    {is_white, is_blue, is_green, is_red} = f;
  endtask

  task automatic pixels(input int n, input int x, input logic [3:0] f);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pix_valid = 1'b1;
      pix_x     = x[8:0];
      pix_y     = 8'd120;
      set_flags(f);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pix_valid = 1'b0;
    set_flags(4'b0000);
  endtask

  task automatic end_frame(input int r, input int g, input int b, input int w,
                           input logic [3:0] ef);
    @(posedge clk); #1;
    frame_end = 1'b1;
    pix_valid = (ef != 4'b0000);
    pix_x     = 9'd150;
    pix_y     = 8'd120;
    set_flags(ef);
    exp_q.push_back(3'(decide(r + int'(ef[0]), g + int'(ef[1]), b + int'(ef[2]),
                              w + int'(ef[3]))));
    @(posedge clk); #1;
    frame_end = 1'b0;
    pix_valid = 1'b0;
    set_flags(4'b0000);
  endtask

  task automatic frame(input int r, input int g, input int b, input int w, input int x,
                       input int nm, input logic [3:0] ef);
    bit in_roi;
    in_roi = (x >= 100) && (x < 220);
    pixels(r, x, 4'b0001);
    pixels(g, x, 4'b0010);
    pixels(b, x, 4'b0100);
    pixels(w, x, 4'b1000);
    pixels(nm, x, 4'b0011);
    if (in_roi) end_frame(r, g, b, w, ef);
    else        end_frame(0, 0, 0, 0, ef);
  endtask

  // Lands two clocks after frame_end, when state-driven outputs have updated.
  task automatic settle();
    @(posedge clk); #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_out("reset", 0, 1, 0);
    check("reset.frame_color", frame_color, 0);
    reset = 1'b1;

    // Colour lock after three stable RED frames.
    frame(3000, 0, 0, 0, 150, 0, 4'b0000);
    settle();
    check("first_decision.white_detected", white_detected, 0);
    frame(3000, 0, 0, 0, 150, 0, 4'b0000);
    frame(3000, 0, 0, 0, 150, 0, 4'b0000);
    settle();
    check_out("red_lock", 1, 0, 1);

    // Unacknowledged result survives stable WHITE.
    for (int i = 0; i < 5; i++) begin
      frame(0, 0, 0, WhitePx, 150, 0, 4'b0000);
      settle();
      check_out("report_white", 1, 0, 1);
    end

    // Ack coincident with a decision lands in HOLD.
    frame(0, 0, 0, WhitePx, 150, 0, 4'b0000);
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    #1;
    check_out("ack_coincident", 1, 0, 0);

    // Fresh debounce in HOLD: WHITE returns only after three more frames.
    for (int i = 0; i < 3; i++) begin
      frame(0, 0, 0, WhitePx, 150, 0, 4'b0000);
      settle();
      if (i < 2) check_out("hold_white", 1, 0, 0);
      else       check_out("back_to_white", 0, 1, 0);
    end

    // ROI gating, tie, threshold, multi-flag, frame_end pixel inclusion.
    frame(0, 5000, 0, 0, 50, 0, 4'b0000);
    settle();
    check_out("roi_armed", 0, 0, 0);
    frame(2500, 0, 2500, 0, 150, 0, 4'b0000);
    frame(1999, 0, 0, 0, 150, 100, 4'b0000);
    frame(1999, 0, 0, 0, 150, 0, 4'b0001);
    settle();
    check_out("armed_after_red", 0, 0, 0);

    // Back-to-back empty frames: two NONE decisions.
    @(posedge clk); #1;
    frame_end = 1'b1;
    exp_q.push_back(3'd0);
    @(posedge clk); #1;
    exp_q.push_back(3'd0);
    @(posedge clk); #1;
    frame_end = 1'b0;

    // Debounce break: RED, RED, BLUE, BLUE, BLUE.
    for (int i = 0; i < 5; i++) begin
      if (i < 2) frame(MinPx, 0, 0, 0, 150, 0, 4'b0000);
      else       frame(0, 0, MinPx, 0, 150, 0, 4'b0000);
      settle();
      if (i < 4) check_out("debounce_armed", 0, 0, 0);
      else       check_out("debounce_lock", 3, 0, 1);
    end

    // Asynchronous reset while in REPORT.
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_out("reset_mid_report", 0, 1, 0);
    check("reset_mid_report.frame_color", frame_color, 0);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-frame discards the partial counts.
    pixels(1200, 150, 4'b0001);
    idle();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    frame(1000, 0, 0, 0, 150, 0, 4'b0000);
    settle();
    check_out("after_reset_frame", 0, 0, 0);

    // Saturation of the green counter.
    pixels(32768, 150, 4'b0010);
    idle();
    check("cnt_g_saturated", int'(dut.cnt_q[1]), SatMax);
    end_frame(0, 32768, 0, 0, 4'b0000);
    settle();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
